// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-port synchronous program/data RAM (1-cycle read latency)
// between the CPU control path and the program loader/debug port.
// One access is in flight at a time: IDLE -> ISSUE_<owner> -> RESP -> IDLE.
// Arbitration is round-robin on contention, except that the loader wins every
// contention while the CPU is halted.
// Optional build macro: ARB_STATS_EN adds a saturating 16-bit contention
// counter on output arb_conflicts.

module mem_port_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          Clock,
    input  logic          Reset,

    input  logic          cpu_halted,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
`ifdef ARB_STATS_EN
    output logic [15:0]   arb_conflicts,
`endif
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE_CPU = 2'd1,
        ST_ISSUE_LDR = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_LDR = 1'b1
    } req_t;

    state_t          state_r;
    req_t            owner_r;     // requester that owns the access in flight
    req_t            last_gnt_r;  // most recent winner, for round-robin
    logic            resp_we_r;   // access in flight is a write: return zero data

    logic            any_req_s;
    req_t            winner_s;
    logic            win_we_s;
    logic [AW-1:0]   win_addr_s;
    logic [DW-1:0]   win_wdata_s;

    // Arbitration rule applied while IDLE. A lone requester always wins.
    // On contention the loader wins while the CPU is halted; otherwise the
    // requester that did not win last time gets the slot.
    function automatic req_t pick_winner(
        input logic halted,
        input logic c_req,
        input logic l_req,
        input req_t last
    );
        req_t w;
        if (c_req && l_req) begin
            if (halted) begin
                w = REQ_LDR;
            end else if (last == REQ_LDR) begin
                w = REQ_CPU;
            end else begin
                w = REQ_LDR;
            end
        end else if (l_req) begin
            w = REQ_LDR;
        end else begin
            w = REQ_CPU;
        end
        return w;
    endfunction

    assign any_req_s = cpu_req | ldr_req;
    assign winner_s  = pick_winner(cpu_halted, cpu_req, ldr_req, last_gnt_r);

    // Select the winning requester's access attributes for capture in IDLE.
    always_comb begin
        win_we_s    = 1'b0;
        win_addr_s  = {AW{1'b0}};
        win_wdata_s = {DW{1'b0}};
        if (winner_s == REQ_CPU) begin
            win_we_s    = cpu_we;
            win_addr_s  = cpu_addr;
            win_wdata_s = cpu_wdata;
        end else begin
            win_we_s    = ldr_we;
            win_addr_s  = ldr_addr;
            win_wdata_s = ldr_wdata;
        end
    end

    // Arbiter FSM with registered grant, response and RAM-side outputs.
    // Pulses (gnt, rvalid, mem_en, mem_we) default low every cycle and are
    // raised only in the state that owns them. An asynchronous reset kills
    // an in-flight access before the RAM samples it, and no rvalid follows.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r    <= ST_IDLE;
            owner_r    <= REQ_CPU;
            last_gnt_r <= REQ_LDR;
            resp_we_r  <= 1'b0;
            cpu_gnt    <= 1'b0;
            ldr_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {AW{1'b0}};
            mem_wdata  <= {DW{1'b0}};
        end else begin
            cpu_gnt    <= 1'b0;
            ldr_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        owner_r    <= winner_s;
                        last_gnt_r <= winner_s;
                        resp_we_r  <= win_we_s;
                        mem_en     <= 1'b1;
                        mem_we     <= win_we_s;
                        mem_addr   <= win_addr_s;
                        mem_wdata  <= win_wdata_s;
                        if (winner_s == REQ_CPU) begin
                            cpu_gnt <= 1'b1;
                            state_r <= ST_ISSUE_CPU;
                        end else begin
                            ldr_gnt <= 1'b1;
                            state_r <= ST_ISSUE_LDR;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE_CPU: begin
                    cpu_rvalid <= 1'b1;
                    state_r    <= ST_RESP;
                end
                ST_ISSUE_LDR: begin
                    ldr_rvalid <= 1'b1;
                    state_r    <= ST_RESP;
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Steer RAM read data to the owner only during its rvalid cycle; write
    // completions and the non-owner always see zero.
    always_comb begin
        cpu_rdata = {DW{1'b0}};
        ldr_rdata = {DW{1'b0}};
        if (cpu_rvalid && (owner_r == REQ_CPU) && !resp_we_r) begin
            cpu_rdata = mem_rdata;
        end else begin
            cpu_rdata = {DW{1'b0}};
        end
        if (ldr_rvalid && (owner_r == REQ_LDR) && !resp_we_r) begin
            ldr_rdata = mem_rdata;
        end else begin
            ldr_rdata = {DW{1'b0}};
        end
    end

`ifdef ARB_STATS_EN
    // Count IDLE cycles in which both requesters compete; saturate at max.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            arb_conflicts <= 16'h0000;
        end else if ((state_r == ST_IDLE) && cpu_req && ldr_req &&
                     (arb_conflicts != 16'hFFFF)) begin
            arb_conflicts <= arb_conflicts + 16'h0001;
        end else begin
            arb_conflicts <= arb_conflicts;
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified program/data RAM of the accumulator processor between two requesters: the CPU control path (instruction fetch, operand load/store) and the program loader/debug port. One access is in flight at a time. Arbitration is round-robin, except that the loader gets absolute priority while the CPU is halted. The block sits between both requesters and the synchronous RAM, which has 1-cycle read latency.

Parameters:
AW, 5, memory address width
DW, 8, memory data width

Ports:
Clock  input  1  system clock
Reset  input  1  asynchronous, active-high reset
cpu_halted  input  1  CPU controller in halt state; switches the arbiter to loader-first
cpu_req  input  1  CPU access request; held until cpu_gnt
cpu_we  input  1  CPU write enable (1=write, 0=read)
cpu_addr  input  AW  CPU address
cpu_wdata  input  DW  CPU write data
cpu_gnt  output  1  one-cycle pulse: CPU access issued to RAM
cpu_rvalid  output  1  one-cycle pulse: CPU access complete (read data valid, or write acknowledged)
cpu_rdata  output  DW  CPU read data, valid with cpu_rvalid
ldr_req, ldr_we, ldr_addr, ldr_wdata  input  1/1/AW/DW  loader request bundle, same rules as CPU
ldr_gnt, ldr_rvalid, ldr_rdata  output  1/1/DW  loader response bundle, same rules as CPU
mem_en  output  1  RAM enable
mem_we  output  1  RAM write enable
mem_addr  output  AW  RAM address
mem_wdata  output  DW  RAM write data
mem_rdata  input  DW  RAM read data, valid 1 cycle after mem_en

Behaviour:
- Reset: Reset (asynchronous, active-high) is applied with Clock as the clock.
  - All outputs are 0, including mem_en, mem_we, mem_addr and mem_wdata.
  - State is IDLE. last_gnt is reset to LDR, so the CPU wins the first contention.
- FSM states: IDLE, ISSUE_CPU, ISSUE_LDR, RESP. All outputs are registered except x_rdata.
- IDLE:
  - No request: stay in IDLE.
  - One request: that requester wins.
  - Both requesting, cpu_halted=1: loader wins.
  - Both requesting, cpu_halted=0: the requester not equal to last_gnt wins.
  - On a win: capture the winner's we/addr/wdata, record the winner as owner and in last_gnt, then go to ISSUE_<winner>.
- ISSUE_x (exactly 1 cycle):
  - mem_en=1; mem_we/mem_addr/mem_wdata = captured values.
  - x_gnt=1.
  - Next state: RESP.
- RESP (exactly 1 cycle):
  - mem_en=0, mem_we=0.
  - Owner's rvalid=1.
  - x_rdata = mem_rdata while x_rvalid=1, else 0. For writes, rdata content is don't-care but driven 0.
  - Next state: IDLE.
- Latency: request sampled in IDLE at edge N; gnt and RAM access in cycle N+1; rvalid in cycle N+2.
- Throughput: one access per 3 cycles.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt.
  - A request dropped after being sampled in IDLE still completes.
  - To issue another access, drop req or keep it high after gnt; keeping it high counts as a new request in the next IDLE.
  - Inputs are captured only in IDLE; changes during ISSUE/RESP are ignored.
- Fairness: with cpu_halted=0 and both continuously requesting, grants strictly alternate CPU, LDR, CPU, ...
- cpu_halted is sampled only in IDLE.
- Reset mid-operation: outputs drop to 0 immediately (asynchronous). An in-flight ISSUE write is aborted (mem_en=0), and no rvalid is generated for the discarded access.
- gnt and rvalid never assert for both requesters in the same cycle.
- mem_we=1 only when mem_en=1.

Optional Feature:
ARB_STATS_EN:
- Defined: adds output arb_conflicts [15:0].
  - Increments each cycle the FSM is in IDLE with cpu_req=1 and ldr_req=1.
  - Saturates at 16'hFFFF; reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset asserted for 2 cycles, then released -> all outputs 0; FSM in IDLE; first contention grants CPU.
- RAM[5]=8'h3C; CPU read of addr 5 with req at edge 0 -> cycle 1: cpu_gnt=1, mem_en=1, mem_we=0, mem_addr=5; cycle 2: cpu_rvalid=1, cpu_rdata=8'h3C; ldr_* outputs stay 0.
- Loader write addr 31, data 8'hA5, then CPU read addr 31 -> mem_we=1 with mem_wdata=8'hA5 in the loader ISSUE cycle; CPU read returns 8'hA5; ldr_rvalid pulses once.
- Both requesters continuously requesting, cpu_halted=0, for 6 grants -> grant order CPU, LDR, CPU, LDR, CPU, LDR; each gnt is 3 cycles apart. With ARB_STATS_EN, arb_conflicts=6.
- Same stimulus with cpu_halted=1 -> all 6 grants go to the loader; cpu_gnt stays 0.
- Reset asserted in the ISSUE_LDR cycle of a write of 8'hFF to addr 2 (RAM[2]=8'h11) -> mem_en drops immediately; RAM[2] remains 8'h11; no ldr_rvalid; FSM in IDLE after release.
